core_mem_responder: RTL and testbench
=====================================

// Module: core_mem_responder
// PURPOSE
//  Memory-side responder for the pipelined core. Serves its instruction-fetch port (word-addressed PC)
//  and its data port (RAM_IN_* in, RAM_OUT back) from flop arrays, plus a byte-serial program loader.
//  The loader fills instruction memory from chip pins while the core is held in reset.
//  Sits beside the core in the top level; core_hold is ORed into the core's clr.
// PARAMETERS
//  IMEM_WORDS  16     instruction words; power of two, <=256
//  DMEM_WORDS  16     data words; power of two
//  MMIO_ADDR   32'hFF data word address of the GPIO output register (only with CORE_MEM_MMIO_EN)
// PORTS
//  clk         in   1   system clock; all state updates on rising edge
//  clr         in   1   synchronous, active-high reset
//  imem_addr   in   8   instruction word address (core PC[7:0])
//  imem_rdata  out  32  instruction word, combinational
//  ram_addr    in   32  data word address (core ALU result in MEM stage)
//  ram_wdata   in   32  store data
//  ram_we      in   1   store strobe, one word per cycle while high
//  ram_rdata   out  32  load data, combinational
//  load_en     in   1   loader session enable (level)
//  load_valid  in   1   load_byte qualifier, one byte per cycle high
//  load_byte   in   8   program byte, little-endian within each word
//  core_hold   out  1   hold core in reset
//  load_done   out  1   set when a session ends with >=1 committed word
//  load_count  out  8   words committed in current/last session
//  gpio_out    out  8   MMIO output register
// BEHAVIOUR
//  Reset: state=IDLE, byte_cnt=0, load_addr=0, load_count=0, load_done=0, gpio_out=0, DMEM all 0.
//   IMEM is NOT cleared by clr (program survives core reset). core_hold=0 after reset unless load_en=1.
//  Reads: zero latency, combinational from address (core samples them at the same edge as its pipe regs).
//   imem_addr >= IMEM_WORDS -> imem_rdata=32'h0000_0013 (NOP). ram_addr indexes DMEM by low log2(DMEM_WORDS) bits.
//  Writes: ram_we=1 writes DMEM[idx]<=ram_wdata at the edge; read-after-write same address visible next cycle.
//   ram_we ignored while core_hold=1.
//  FSM states IDLE, LOAD, COMMIT:
//   IDLE:   load_en=1 -> LOAD; clear load_addr, byte_cnt, load_count, load_done.
//   LOAD:   load_valid=1 -> word[8*byte_cnt+:8]<=load_byte, byte_cnt++; 4th byte -> COMMIT.
//           load_en=0 -> IDLE, partial word discarded, load_done=(load_count!=0).
//   COMMIT: IMEM[load_addr]<=word; load_addr wraps IMEM_WORDS-1 -> 0; load_count++ (saturates 255);
//           byte_cnt=0; -> LOAD if load_en else IDLE with load_done=1. load_valid in COMMIT is dropped.
//  core_hold = load_en | (state!=IDLE), combinational.
//  clr mid-session: FSM to IDLE immediately, partial word lost, IMEM words already committed kept.
// CONFIGURATION
//  CORE_MEM_MMIO_EN defined: ram_addr==MMIO_ADDR with ram_we -> gpio_out<=ram_wdata[7:0], DMEM untouched;
//   read of MMIO_ADDR returns {24'b0,gpio_out}.
//  Undefined: no decode; MMIO_ADDR is ordinary DMEM (wraps), gpio_out tied 8'h00.
// TESTING
//  1 clr, load_en=1, bytes 13,00,00,00,93,00,10,00 -> IMEM[0]=32'h00000013, IMEM[1]=32'h00100093, load_count=2.
//  2 drop load_en after 2 bytes of word 3 -> IDLE next cycle, IMEM[2] unchanged, load_done=1, core_hold=0.
//  3 ram_we=1 addr=5 data=32'hDEADBEEF, next cycle addr=5 -> ram_rdata=DEADBEEF; addr=21 -> same (wrap).
//  4 imem_addr=8'h40 with IMEM_WORDS=16 -> imem_rdata=32'h00000013; ram_we during load_en=1 -> DMEM unchanged.
//  5 MMIO_EN: store 32'h1234_56A5 to 32'hFF -> gpio_out=8'hA5, DMEM[15] still 0; undefined: gpio_out=0.
//  6 load 17 words with IMEM_WORDS=16 -> word 16 overwrites IMEM[0], load_count=17; clr leaves IMEM intact.

Source files
------------

// File: rtl/core_mem_responder.sv
// Instruction/data memory responder with byte-serial program loader.
// Optional GPIO output register at MMIO_ADDR when CORE_MEM_MMIO_EN is defined.
module core_mem_responder #(
    parameter int          IMEM_WORDS = 16,
    parameter int          DMEM_WORDS = 16,
    parameter logic [31:0] MMIO_ADDR  = 32'hFF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  imem_addr,
    output logic [31:0] imem_rdata,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_wdata,
    input  logic        ram_we,
    output logic [31:0] ram_rdata,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        core_hold,
    output logic        load_done,
    output logic [7:0]  load_count,
    output logic [7:0]  gpio_out
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam logic [31:0]    NOP      = 32'h0000_0013;
    localparam logic [IAW-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t         state;
    logic [1:0]     byte_cnt;
    logic [IAW-1:0] load_addr;
    logic [31:0]    word;
    logic [31:0]    imem [IMEM_WORDS];
    logic [31:0]    dmem [DMEM_WORDS];
    logic [DAW-1:0] ram_idx;
    logic           imem_hit;
    logic           store_ok;
    logic           mmio_hit;

    assign ram_idx    = ram_addr[DAW-1:0];
    assign imem_hit   = {24'd0, imem_addr} < IMEM_WORDS;
    assign imem_rdata = imem_hit ? imem[imem_addr[IAW-1:0]] : NOP;
    assign core_hold  = load_en | (state != IDLE);
    assign store_ok   = ram_we & ~core_hold;

`ifdef CORE_MEM_MMIO_EN
    logic [7:0] gpio_q;

    assign mmio_hit  = (ram_addr == MMIO_ADDR);
    assign gpio_out  = gpio_q;
    assign ram_rdata = mmio_hit ? {24'd0, gpio_q} : dmem[ram_idx];

    always_ff @(posedge clk) begin
        if (clr) begin
            gpio_q <= 8'h00;
        end else if (store_ok && mmio_hit) begin
            gpio_q <= ram_wdata[7:0];
        end
    end
`else
    logic unused_addr_bits;

    assign mmio_hit         = 1'b0;
    assign gpio_out         = 8'h00;
    assign ram_rdata        = dmem[ram_idx];
    assign unused_addr_bits = ^ram_addr[31:DAW];
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem[i] <= '0;
            end
        end else if (store_ok && !mmio_hit) begin
            dmem[ram_idx] <= ram_wdata;
        end
    end

    // No reset on IMEM: the loaded program must survive core resets.
    always_ff @(posedge clk) begin
        if (!clr && state == COMMIT) begin
            imem[load_addr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            load_addr  <= '0;
            load_count <= 8'd0;
            load_done  <= 1'b0;
            word       <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_en) begin
                        state      <= LOAD;
                        byte_cnt   <= 2'd0;
                        load_addr  <= '0;
                        load_count <= 8'd0;
                        load_done  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!load_en) begin
                        state     <= IDLE;
                        load_done <= (load_count != 8'd0);
                    end else if (load_valid) begin
                        word[{byte_cnt, 3'b000} +: 8] <= load_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    load_addr <= load_addr + ADDR_ONE;
                    byte_cnt  <= 2'd0;
                    if (load_count != 8'hFF) begin
                        load_count <= load_count + 8'd1;
                    end
                    if (load_en) begin
                        state <= LOAD;
                    end else begin
                        state     <= IDLE;
                        load_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: data-port vector table plus loader sequences.
// Expected IMEM words go through a scoreboard queue checked at each commit.
module tb_core_mem_responder;
    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        load_en;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        core_hold;
    logic        load_done;
    logic [7:0]  load_count;
    logic [7:0]  gpio_out;

    core_mem_responder dut (
        .clk(clk),
        .clr(clr),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we(ram_we),
        .ram_rdata(ram_rdata),
        .load_en(load_en),
        .load_valid(load_valid),
        .load_byte(load_byte),
        .core_hold(core_hold),
        .load_done(load_done),
        .load_count(load_count),
        .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

`ifdef CORE_MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        hold;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } imem_exp_t;

    int          total = 0;
    int          bad = 0;
    vec_t        vt[12];
    imem_exp_t   sb[$];
    logic [3:0]  mdl_addr;
    logic [31:0] imem_mdl[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_session();
        load_en = 1'b1;
        step();
        mdl_addr = 4'd0;
        check("sess_done_clr", load_done, 1'b0);
        check("sess_cnt_clr", load_count, 8'd0);
        check("sess_hold", core_hold, 1'b1);
    endtask

    task automatic end_session(input logic exp_done, input logic [7:0] exp_cnt);
        load_en    = 1'b0;
        load_valid = 1'b0;
        step();
        check("end_hold", core_hold, 1'b0);
        check("end_done", load_done, exp_done);
        check("end_count", load_count, exp_cnt);
    endtask

    task automatic load_word(input logic [31:0] w);
        imem_exp_t e;
        e.addr = {4'd0, mdl_addr};
        e.data = w;
        sb.push_back(e);
        imem_mdl[mdl_addr] = w;
        mdl_addr = mdl_addr + 4'd1;
        for (int b = 0; b < 4; b++) begin
            load_valid = 1'b1;
            load_byte  = w[8*b +: 8];
            step();
        end
        load_valid = 1'b0;
        load_byte  = 8'h00;
        step();
        e = sb.pop_front();
        imem_addr = e.addr;
        #1;
        check("imem_commit", imem_rdata, e.data);
    endtask

    task automatic check_imem_all(input string name);
        for (int a = 0; a < 16; a++) begin
            imem_addr = 8'(a);
            #1;
            check(name, imem_rdata, imem_mdl[a]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{32'd5,  1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[1]  = '{32'd5,  1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{32'd21, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[3]  = '{32'd37, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[4]  = '{32'd3,  1'b1, 32'h00001111, 1'b0, 32'h0};
        vt[5]  = '{32'd19, 1'b0, 32'h0,        1'b0, 32'h00001111};
        vt[6]  = '{32'd15, 1'b0, 32'h0,        1'b0, 32'h0};
        vt[7]  = '{32'hFF, 1'b1, 32'h123456A5, 1'b0, 32'h0};
        vt[8]  = '{32'd15, 1'b0, 32'h0,        1'b0,
                   MMIO ? 32'h0 : 32'h123456A5};
        vt[9]  = '{32'hFF, 1'b0, 32'h0,        1'b0,
                   MMIO ? 32'h000000A5 : 32'h123456A5};
        vt[10] = '{32'd7,  1'b1, 32'hCAFEF00D, 1'b1, 32'h0};
        vt[11] = '{32'd7,  1'b0, 32'h0,        1'b0, 32'h0};

        clr        = 1'b1;
        imem_addr  = 8'd0;
        ram_addr   = 32'd0;
        ram_wdata  = 32'd0;
        ram_we     = 1'b0;
        load_en    = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'd0;
        step();
        step();
        clr = 1'b0;
        #1;
        check("rst_hold", core_hold, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_count", load_count, 8'd0);
        check("rst_gpio", gpio_out, 8'd0);
        check("rst_dmem", ram_rdata, 32'd0);

        for (int i = 0; i < 12; i++) begin
            ram_addr  = vt[i].addr;
            ram_we    = vt[i].we;
            ram_wdata = vt[i].wdata;
            load_en   = vt[i].hold;
            #1;
            check($sformatf("vec%0d_rdata", i), ram_rdata, vt[i].exp);
            step();
        end
        ram_we  = 1'b0;
        load_en = 1'b0;
        step();
        check("gpio_after", gpio_out, MMIO ? 8'hA5 : 8'h00);
        check("idle_after_vec", core_hold, 1'b0);

        start_session();
        step();
        end_session(1'b0, 8'd0);

        start_session();
        load_word(32'h00000013);
        load_word(32'h00100093);
        end_session(1'b1, 8'd2);

        start_session();
        load_word(32'h11111111);
        load_word(32'h22222222);
        load_word(32'h33333333);
        end_session(1'b1, 8'd3);

        start_session();
        load_word(32'h44444444);
        load_word(32'h55555555);
        load_valid = 1'b1;
        load_byte  = 8'h66;
        step();
        step();
        end_session(1'b1, 8'd2);
        imem_addr = 8'd2;
        #1;
        check("partial_kept", imem_rdata, 32'h33333333);

        start_session();
        for (int i = 0; i < 17; i++) begin
            load_word(32'hA000_0000 + 32'(i));
        end
        end_session(1'b1, 8'd17);
        check_imem_all("imem_wrap");

        for (int i = 0; i < 3; i++) begin
            imem_addr = (i == 0) ? 8'h10 : ((i == 1) ? 8'h40 : 8'hFF);
            #1;
            check($sformatf("nop_%0d", i), imem_rdata, 32'h00000013);
        end

        clr = 1'b1;
        step();
        clr = 1'b0;
        ram_addr = 32'd5;
        #1;
        check("clr_count", load_count, 8'd0);
        check("clr_done", load_done, 1'b0);
        check("clr_dmem", ram_rdata, 32'd0);
        check_imem_all("imem_after_clr");

        load_en = 1'b1;
        step();
        load_valid = 1'b1;
        load_byte  = 8'hAA;
        step();
        load_byte  = 8'hBB;
        step();
        clr        = 1'b1;
        load_valid = 1'b0;
        step();
        clr = 1'b0;
        check("clr_mid_hold", core_hold, 1'b1);
        check("clr_mid_count", load_count, 8'd0);
        step();
        mdl_addr = 4'd0;
        load_word(32'h77665544);
        end_session(1'b1, 8'd1);
        check_imem_all("imem_after_mid_clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
